pipe_gen: RTL and testbench
===========================

PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 Parameter TICK_DIV, default 25000000, enabled clock cycles per column shift; legal range 2 or more.
REQ-002 Parameter ROWS, default 8, number of LED rows in one column.
REQ-003 Parameter GAP_HEIGHT, default 3, number of open rows in each pipe; legal range 1 to ROWS-2.
REQ-004 Parameter GAP_COLS, default 3, number of empty columns between pipes; legal range 1 or more.
REQ-005 Parameter PIPE_WIDTH, default 1, number of columns each pipe occupies; legal range 1 or more.
REQ-006 Port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port Reset, input, 1 bit: reset is synchronous and active-low.
REQ-008 Port Enable, input, 1 bit: game running; when 0, all scrolling freezes.
REQ-009 Port Shift, output, 1 bit: one-cycle column-shift strobe; drives the shift/turn-off input of every playfield cell.
REQ-010 Port PipeCol, output, ROWS bits: column pattern injected into the rightmost playfield column; bit r=1 means row r lit.
REQ-011 Port GapTop, output, 3 bits: lowest row index of the gap in the current or most recent pipe.
REQ-012 Port PipeCount, output, 8 bits: number of pipes fully emitted, saturating.

Function
REQ-013 Tick counter SHALL count 0..TICK_DIV-1, advance only when Enable=1, and wrap to 0 after TICK_DIV-1.
REQ-014 Shift SHALL be 1 exactly in a cycle with Enable=1 and tick counter = TICK_DIV-1; otherwise 0.
REQ-015 With Enable held at 0, the tick counter, FSM, column counter, GapTop and PipeCount SHALL hold.
REQ-016 FSM states SHALL be SPACE and PIPE. A column counter SHALL count Shift pulses within the current state.
REQ-017 PipeCol SHALL be a Moore output of registered state only, valid throughout any cycle where Shift=1.
REQ-018 In SPACE, PipeCol SHALL be all zeros.
REQ-019 In PIPE, PipeCol bit r SHALL be 0 for GapTop <= r <= GapTop+GAP_HEIGHT-1 and 1 for all other rows.
REQ-020 SPACE to PIPE transition: on the Shift edge completing GAP_COLS columns in SPACE. The column counter SHALL clear and GapTop SHALL load the new gap position on that same edge.
REQ-021 PIPE to SPACE transition: on the Shift edge completing PIPE_WIDTH columns in PIPE. The column counter SHALL clear and PipeCount SHALL increment on that same edge, unless PipeCount = 255, in which case it holds.
REQ-022 LFSR: 8-bit Fibonacci LFSR that shifts left every clock, regardless of Enable.
REQ-023 LFSR feedback: new bit0 = b7^b5^b4^b3.
REQ-024 LFSR value SHALL never be all zeros.
REQ-025 Gap position: take v = LFSR[2:0] and M = ROWS-GAP_HEIGHT. The gap position SHALL be v if v <= M, else v-(M+1). GapTop SHALL therefore always lie in 0..M.
REQ-026 Shift and PipeCol SHALL be glitch-free registered or Moore-decoded values; no output SHALL depend combinationally on Enable except Shift.

Reset
REQ-027 When Reset=0 at a rising edge, the block SHALL force: state SPACE, column counter 0, tick counter 0, GapTop 0, PipeCount 0, LFSR 8'hA5.
REQ-028 During and immediately after reset, Shift=0 and PipeCol=0.
REQ-029 Reset asserted mid-pipe or mid-tick SHALL take priority over Enable and any pending Shift.

Verification (TICK_DIV=4, ROWS=8, GAP_HEIGHT=3, GAP_COLS=3, PIPE_WIDTH=1)
REQ-030 Reset=0 for 3 cycles -> Shift=0, PipeCol=8'h00, GapTop=0, PipeCount=0, LFSR=8'hA5.
REQ-031 Release reset, Enable=1 -> Shift pulses exactly 1 cycle wide on enabled cycles 4, 8, 12, ...; never two consecutive cycles.
REQ-032 First 3 Shifts -> PipeCol=8'h00. 4th Shift -> PipeCol has exactly 3 contiguous zeros starting at GapTop (in 0..5), other bits 1. PipeCount=1 after that edge. 5th Shift -> PipeCol=8'h00. Pattern repeats with period 4 Shifts.
REQ-033 Enable=0 for 10 cycles after tick counter reaches 2 -> no Shift, all outputs hold; next Shift occurs 2 enabled cycles after Enable returns to 1.
REQ-034 Reset=0 for 1 cycle while in PIPE -> next cycle SPACE, PipeCol=8'h00, PipeCount=0; first pipe reappears on the 4th subsequent Shift.
REQ-035 Run 300 pipes -> PipeCount stops at 255. GapTop stays in 0..5 and matches a reference LFSR model. Every PipeCol in PIPE has exactly 5 bits set.

Source files
------------

// File: rtl/pipe_gen.sv
// Scrolling pipe generator: a tick divider paces column shifts; a SPACE/PIPE FSM
// emits empty columns and pipe columns whose gap row comes from a free-running LFSR.
module pipe_gen #(
  parameter int TICK_DIV   = 25000000,
  parameter int ROWS       = 8,
  parameter int GAP_HEIGHT = 3,
  parameter int GAP_COLS   = 3,
  parameter int PIPE_WIDTH = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  output logic            Shift,
  output logic [ROWS-1:0] PipeCol,
  output logic [2:0]      GapTop,
  output logic [7:0]      PipeCount,
  output logic            fsm_state,
  output logic [7:0]      lfsr_state
);

  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX  = (GAP_COLS > PIPE_WIDTH) ? GAP_COLS : PIPE_WIDTH;
  localparam int CW    = $clog2(CMAX) + 1;
  localparam int M     = ROWS - GAP_HEIGHT;

  typedef enum logic {SPACE = 1'b0, PIPE = 1'b1} state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  tick;
  logic [CW-1:0]  col_cnt, col_nx;
  logic [2:0]     gap_top, gap_nx;
  logic [7:0]     pipe_count;
  logic [7:0]     lfsr;
  logic           load_gap, pipe_done;

  // Reset gating keeps the strobe low while Reset is held, before any edge lands.
  assign Shift = Reset & Enable & (tick == TW'(TICK_DIV - 1));

  // Values 0..M map directly; larger LFSR values fold back to the low rows.
  always_comb begin
    gap_nx = lfsr[2:0];
    if (int'(lfsr[2:0]) > M) gap_nx = 3'(int'(lfsr[2:0]) - M - 1);
  end

  always_comb begin
    state_nx  = state;
    col_nx    = col_cnt;
    load_gap  = 1'b0;
    pipe_done = 1'b0;
    if (Shift) begin
      case (state)
        SPACE: begin
          if (col_cnt == CW'(GAP_COLS - 1)) begin
            state_nx = PIPE;
            col_nx   = '0;
            load_gap = 1'b1;
          end else begin
            col_nx = col_cnt + 1'b1;
          end
        end
        PIPE: begin
          if (col_cnt == CW'(PIPE_WIDTH - 1)) begin
            state_nx  = SPACE;
            col_nx    = '0;
            pipe_done = 1'b1;
          end else begin
            col_nx = col_cnt + 1'b1;
          end
        end
        default: state_nx = SPACE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= SPACE;
      col_cnt    <= '0;
      tick       <= '0;
      gap_top    <= '0;
      pipe_count <= '0;
      lfsr       <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (Enable) tick <= (tick == TW'(TICK_DIV - 1)) ? '0 : tick + 1'b1;
      state   <= state_nx;
      col_cnt <= col_nx;
      if (load_gap) gap_top <= gap_nx;
      if (pipe_done && pipe_count != 8'hFF) pipe_count <= pipe_count + 8'd1;
    end
  end

  // Column pattern is decoded from registered state only.
  always_comb begin
    PipeCol = '0;
    if (state == PIPE) begin
      for (int r = 0; r < ROWS; r++) begin
        PipeCol[r] = !((r >= int'(gap_top)) && (r <= int'(gap_top) + GAP_HEIGHT - 1));
      end
    end
  end

  assign GapTop     = gap_top;
  assign PipeCount  = pipe_count;
  assign fsm_state  = state;
  assign lfsr_state = lfsr;

endmodule

// File: tb/tb_pipe_gen.sv
// Randomized bench for pipe_gen against a shift-count based reference model.
module tb_pipe_gen;
  localparam int TICK_DIV   = 4;
  localparam int ROWS       = 8;
  localparam int GAP_HEIGHT = 3;
  localparam int GAP_COLS   = 3;
  localparam int PIPE_WIDTH = 1;
  localparam int P          = GAP_COLS + PIPE_WIDTH;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            Enable = 1'b0;
  logic            Shift;
  logic [ROWS-1:0] PipeCol;
  logic [2:0]      GapTop;
  logic [7:0]      PipeCount;
  logic            fsm_state;
  logic [7:0]      lfsr_state;

  pipe_gen #(
    .TICK_DIV(TICK_DIV), .ROWS(ROWS), .GAP_HEIGHT(GAP_HEIGHT),
    .GAP_COLS(GAP_COLS), .PIPE_WIDTH(PIPE_WIDTH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Shift(Shift),
    .PipeCol(PipeCol), .GapTop(GapTop), .PipeCount(PipeCount),
    .fsm_state(fsm_state), .lfsr_state(lfsr_state)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ROWS-1:0] exp_q[$];

  // reference model: counts enabled cycles and shifts since reset
  bit       m_valid = 0;
  int       m_en_cycles, m_shifts, m_gap, m_count, m_total;
  bit [7:0] m_lfsr;
  bit       last_shift;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [7:0] lfsr_next(input bit [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  function automatic int gap_of(input bit [7:0] x);
    int v = int'(x[2:0]);
    int m = ROWS - GAP_HEIGHT;
    return (v <= m) ? v : v - (m + 1);
  endfunction

  // driver: one clock cycle with the given inputs, checked before the edge
  task automatic step(input logic en, input logic rst);
    bit exp_shift;
    bit in_pipe;
    logic [ROWS-1:0] exp_col;
    logic [ROWS-1:0] gap_mask;
    int k;
    @(negedge Clock);
    Enable = en;
    Reset  = rst;
    #1;
    exp_shift = 0;
    if (m_valid) begin
      exp_shift = rst && en && ((m_en_cycles % TICK_DIV) == TICK_DIV - 1);
      in_pipe   = (m_shifts % P) >= GAP_COLS;
      gap_mask  = 8'b0000_0111;
      gap_mask  = gap_mask << m_gap;
      exp_col   = in_pipe ? ~gap_mask : '0;
      check("shift", 32'(Shift), 32'(exp_shift));
      check("pipe_col", 32'(PipeCol), 32'(exp_col));
      check("gap_top", 32'(GapTop), 32'(m_gap));
      check("pipe_count", 32'(PipeCount), 32'(m_count));
      check("state", 32'(fsm_state), 32'(in_pipe));
      check("lfsr", 32'(lfsr_state), 32'(m_lfsr));
      if (in_pipe) check("lit_rows", 32'($countones(PipeCol)), 32'(ROWS - GAP_HEIGHT));
      if (exp_shift) exp_q.push_back(exp_col);
      if (Shift) begin
        if (exp_q.size() == 0) check("unexpected_shift", 32'(Shift), 32'(0));
        else check("shift_col", 32'(PipeCol), 32'(exp_q.pop_front()));
      end
    end
    last_shift = Shift;
    @(posedge Clock);
    if (!rst) begin
      m_valid = 1; m_en_cycles = 0; m_shifts = 0; m_gap = 0;
      m_count = 0; m_total = 0; m_lfsr = 8'hA5;
    end else if (m_valid) begin
      if (exp_shift) begin
        k = m_shifts % P;
        if (k == GAP_COLS - 1) m_gap = gap_of(m_lfsr);
        if (k == P - 1) begin
          m_total++;
          if (m_count < 255) m_count++;
        end
        m_shifts++;
      end
      if (en) m_en_cycles++;
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  initial begin
    int cnt;
    int guard;
    int shift_no;
    int pipe_at;

    // reset held 3 cycles with Enable high: Shift must stay low
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // run to tick 2, freeze 10 cycles, then measure resume latency
    guard = 0;
    while ((m_en_cycles % TICK_DIV) != 2 && guard < 20) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("reach_tick2", 32'(m_en_cycles % TICK_DIV), 32'(2));
    repeat (10) step(1'b0, 1'b1);
    cnt = 0;
    last_shift = 0;
    while (!last_shift && cnt < 8) begin
      step(1'b1, 1'b1);
      cnt++;
    end
    check("resume_latency", 32'(cnt), 32'(2));

    // random enable with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) != 0));
    end

    // reset while the pipe column is showing
    guard = 0;
    while (fsm_state !== 1'b1 && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("reach_pipe", 32'(fsm_state), 32'(1));
    step(1'($urandom_range(0, 1)), 1'b0);
    shift_no = 0;
    pipe_at  = 0;
    guard    = 0;
    while (pipe_at == 0 && guard < 200) begin
      step(1'b1, 1'b1);
      if (last_shift) begin
        shift_no++;
        if (PipeCol != '0) pipe_at = shift_no;
      end
      guard++;
    end
    check("first_pipe_shift", 32'(pipe_at), 32'(4));

    // long run past saturation
    guard = 0;
    while (m_total < 300 && guard < 20000) begin
      step(1'($urandom_range(0, 7) != 0), 1'b1);
      guard++;
    end
    check("long_run_done", 32'(m_total >= 300), 32'(1));
    check("saturated", 32'(PipeCount), 32'(255));
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
